ic1406_pattern_checker: RTL and testbench

- Synthesizable built-in self-test block for the ic1406 sequential IC.
- It sits opposite the ic1406: it drives the chip's A0–A2 inputs and checks its Q0/Q1/Z responses.
- It runs three stimulus sets in a fixed order: incrementing, decrementing, then scrambled.
- It scores every response bit against a loadable expected table and reports a 0–100 grade, a mismatch count and the first failing vector.

---
 rtl/ic1406_pattern_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_ic1406_pattern_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ic1406_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : ic1406_pattern_checker
// Description : Built-in self-test sequencer for the ic1406. Drives A0-A2
//               through incrementing, decrementing and scrambled stimulus
//               sets, scores each {Z,Q1,Q0} response against a loadable
//               expected table and reports grade, error count and the first
//               failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module ic1406_pattern_checker (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [2:0] A,
    input  logic [2:0] resp,
    input  logic       exp_we,
    input  logic [4:0] exp_addr,
    input  logic [2:0] exp_data,
    output logic       busy,
    output logic       done,
    output logic [6:0] grade,
    output logic [4:0] err_count,
    output logic       mismatch,
    output logic [4:0] fail_addr,
    output logic       fail_seen
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_DRIVE = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] PH_INC = 2'd0;
    localparam logic [1:0] PH_DEC = 2'd1;
    localparam logic [1:0] PH_SCR = 2'd2;
    localparam logic [1:0] PH_BAD = 2'd3;

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] a_q, a_d;
    logic [6:0] grade_q, grade_d;
    logic [4:0] err_q, err_d;
    logic       mismatch_q, mismatch_d;
    logic [4:0] fail_addr_q, fail_addr_d;
    logic       fail_seen_q, fail_seen_d;

    // Expected response table, 3 phases x 8 vectors; deliberately not reset
    logic [2:0] tbl_q [0:23];

    logic       w_busy;
    logic       w_tbl_we;
    logic [4:0] w_rd_addr;
    logic [2:0] w_exp;
    logic [2:0] w_eq;
    logic [1:0] w_eq_cnt;
    logic [2:0] w_pts;
    logic [2:0] w_init_pts;
    logic [2:0] w_next_idx;
    logic [1:0] w_next_phase;
    logic       w_last;

    // Stimulus value for a given (phase, index) pair
    function automatic logic [2:0] stim(input logic [1:0] ph, input logic [2:0] ix);
        logic [2:0] v;
        v = 3'd0;
        case (ph)
            PH_INC: v = ix;
            PH_DEC: v = 3'd7 - ix;
            PH_SCR: begin
                case (ix)
                    3'd0:    v = 3'd2;
                    3'd1:    v = 3'd4;
                    3'd2:    v = 3'd6;
                    3'd3:    v = 3'd1;
                    3'd4:    v = 3'd0;
                    3'd5:    v = 3'd3;
                    3'd6:    v = 3'd7;
                    default: v = 3'd5;
                endcase
            end
            default: v = 3'd0;
        endcase
        return v;
    endfunction

    assign w_busy   = (state_q == ST_INIT) || (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    // Table is frozen during a run and the unused phase-3 half is never written
    assign w_tbl_we = exp_we && !w_busy && (exp_addr[4:3] != PH_BAD);

    assign w_rd_addr = {phase_q, idx_q};

    // Expected entry for the vector currently being checked
    always_comb begin
        w_exp = 3'd0;
        if (phase_q != PH_BAD) begin
            w_exp = tbl_q[w_rd_addr];
        end
    end

    // Case-equality so that X/Z on resp scores as a wrong bit in simulation
    assign w_eq[0]  = (resp[0] === w_exp[0]);
    assign w_eq[1]  = (resp[1] === w_exp[1]);
    assign w_eq[2]  = (resp[2] === w_exp[2]);
    assign w_eq_cnt = {1'b0, w_eq[0]} + {1'b0, w_eq[1]} + {1'b0, w_eq[2]};
    assign w_pts    = (phase_q == PH_SCR) ? {w_eq_cnt, 1'b0} : {1'b0, w_eq_cnt};

    // Power-up check: 2 points for each of Q0/Q1 reading high
    assign w_init_pts = {({1'b0, resp[0]} + {1'b0, resp[1]}), 1'b0};

    assign w_next_idx   = idx_q + 3'd1;
    assign w_next_phase = (idx_q == 3'd7) ? (phase_q + 2'd1) : phase_q;
    assign w_last       = (phase_q == PH_SCR) && (idx_q == 3'd7);

    // Expected-table write port
    always_ff @(posedge clk) begin
        if (w_tbl_we) begin
            tbl_q[exp_addr] <= exp_data;
        end
    end

    // Run state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 2'd0;
            idx_q       <= 3'd0;
            a_q         <= 3'd0;
            grade_q     <= 7'd0;
            err_q       <= 5'd0;
            mismatch_q  <= 1'b0;
            fail_addr_q <= 5'd0;
            fail_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            grade_q     <= grade_d;
            err_q       <= err_d;
            mismatch_q  <= mismatch_d;
            fail_addr_q <= fail_addr_d;
            fail_seen_q <= fail_seen_d;
        end
    end

    // Sequencer: next state, stimulus and scoring
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        idx_d       = idx_q;
        a_d         = a_q;
        grade_d     = grade_q;
        err_d       = err_q;
        mismatch_d  = 1'b0;
        fail_addr_d = fail_addr_q;
        fail_seen_d = fail_seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                a_d = 3'd0;
                if (start) begin
                    state_d     = ST_INIT;
                    phase_d     = PH_INC;
                    idx_d       = 3'd0;
                    grade_d     = 7'd0;
                    err_d       = 5'd0;
                    fail_addr_d = 5'd0;
                    fail_seen_d = 1'b0;
                end
            end
            ST_INIT: begin
                grade_d = grade_q + {4'd0, w_init_pts};
                phase_d = PH_INC;
                idx_d   = 3'd0;
                a_d     = stim(PH_INC, 3'd0);
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                grade_d = grade_q + {4'd0, w_pts};
                if (w_eq != 3'b111) begin
                    mismatch_d = 1'b1;
                    err_d      = err_q + 5'd1;
                    if (!fail_seen_q) begin
                        fail_addr_d = w_rd_addr;
                        fail_seen_d = 1'b1;
                    end
                end
                if (w_last) begin
                    a_d     = 3'd0;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = w_next_idx;
                    phase_d = w_next_phase;
                    a_d     = stim(w_next_phase, w_next_idx);
                    state_d = ST_DRIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                a_d     = 3'd0;
            end
        endcase
    end

    assign A         = a_q;
    assign busy      = w_busy;
    assign done      = (state_q == ST_DONE);
    assign grade     = grade_q;
    assign err_count = err_q;
    assign mismatch  = mismatch_q;
    assign fail_addr = fail_addr_q;
    assign fail_seen = fail_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_ic1406_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_ic1406_pattern_checker
// Description : Self-checking bench for ic1406_pattern_checker. Responses are
//               played from a per-vector plan; a scoring model derived from
//               the grading rules predicts grade, errors and first failure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ic1406_pattern_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] A;
    logic [2:0] resp;
    logic       exp_we;
    logic [4:0] exp_addr;
    logic [2:0] exp_data;
    logic       busy;
    logic       done;
    logic [6:0] grade;
    logic [4:0] err_count;
    logic       mismatch;
    logic [4:0] fail_addr;
    logic       fail_seen;

    int checks = 0;
    int errors = 0;

    logic [2:0] golden [0:23] = '{
        3'b101, 3'b011, 3'b101, 3'b000, 3'b110, 3'b011, 3'b011, 3'b011,
        3'b011, 3'b011, 3'b011, 3'b011, 3'b110, 3'b101, 3'b011, 3'b101,
        3'b011, 3'b011, 3'b011, 3'b101, 3'b011, 3'b110, 3'b011, 3'b011};
    int scr_seq [0:7] = '{2, 4, 6, 1, 0, 3, 7, 5};

    logic [2:0] tbl_m [0:23];   // what the bench believes the table holds
    logic [2:0] plan  [0:24];   // [0] power-up response, [v+1] response to vector v

    always #5 clk = ~clk;

    ic1406_pattern_checker dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .resp      (resp),
        .exp_we    (exp_we),
        .exp_addr  (exp_addr),
        .exp_data  (exp_data),
        .busy      (busy),
        .done      (done),
        .grade     (grade),
        .err_count (err_count),
        .mismatch  (mismatch),
        .fail_addr (fail_addr),
        .fail_seen (fail_seen)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int stim_of(input int v);
        int ph, ix;
        ph = v / 8;
        ix = v % 8;
        if (ph == 0) return ix;
        if (ph == 1) return 7 - ix;
        return scr_seq[ix];
    endfunction

    function automatic int eq_bits(input logic [2:0] a, input logic [2:0] b);
        int n;
        n = 0;
        for (int k = 0; k < 3; k++) if (a[k] === b[k]) n++;
        return n;
    endfunction

    // Grading rules applied to the whole plan at once
    task automatic model(output int g, output int e, output int fa, output int fs, output int mm);
        int n;
        g  = 2 * (int'(plan[0][0]) + int'(plan[0][1]));
        e  = 0; fa = 0; fs = 0; mm = 0;
        for (int v = 0; v < 24; v++) begin
            n = eq_bits(plan[v+1], tbl_m[v]);
            g += ((v >= 16) ? 2 : 1) * n;
            if (n != 3) begin
                e++;
                mm++;
                if (fs == 0) begin fs = 1; fa = v; end
            end
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            exp_we = 1'b1; exp_addr = 5'(i); exp_data = tbl_m[i];
        end
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    // One complete run in lockstep with the checker, checking A and mismatch each cycle
    task automatic run(input string tag, input bit pulse_start, input bit we_mid,
                       input bit coinc_write, output int g_obs);
        int mm_seen, g, e, fa, fs, mm;
        mm_seen = 0;
        @(negedge clk);
        start = 1'b1;
        if (coinc_write) begin
            exp_we = 1'b1; exp_addr = 5'd23; exp_data = tbl_m[23];
        end
        @(negedge clk);
        start = 1'b0; exp_we = 1'b0;
        chk({tag, ":busy_init"}, busy, 1);
        chk({tag, ":grade_clr"}, grade, 0);
        resp = plan[0];
        for (int v = 0; v < 24; v++) begin
            @(negedge clk);                       // DRIVE cycle
            chk({tag, ":A_drive"}, A, stim_of(v));
            if (v > 0) chk({tag, ":mm_pulse"}, mismatch, (eq_bits(plan[v], tbl_m[v-1]) != 3) ? 1 : 0);
            mm_seen += int'(mismatch);
            resp = 3'($urandom);
            if (pulse_start && (v == 5 || v == 12)) start = 1'b1;
            if (we_mid && v == 9) begin
                exp_we = 1'b1; exp_addr = 5'd0; exp_data = 3'b000;
            end
            @(negedge clk);                       // CHECK cycle
            start = 1'b0; exp_we = 1'b0;
            chk({tag, ":A_hold"}, A, stim_of(v));
            chk({tag, ":busy_run"}, {busy, done}, 2'b10);
            mm_seen += int'(mismatch);
            resp = plan[v+1];
        end
        @(negedge clk);                           // first DONE cycle
        model(g, e, fa, fs, mm);
        chk({tag, ":mm_last"}, mismatch, (eq_bits(plan[24], tbl_m[23]) != 3) ? 1 : 0);
        mm_seen += int'(mismatch);
        chk({tag, ":done"}, {busy, done}, 2'b01);
        chk({tag, ":A_done"}, A, 0);
        chk({tag, ":grade"}, grade, g);
        chk({tag, ":err_count"}, err_count, e);
        chk({tag, ":fail_seen"}, fail_seen, fs);
        if (fs != 0) chk({tag, ":fail_addr"}, fail_addr, fa);
        chk({tag, ":mm_total"}, mm_seen, mm);
        g_obs = int'(grade);
    endtask

    task automatic set_plan_golden();
        plan[0] = 3'b011;
        for (int v = 0; v < 24; v++) plan[v+1] = golden[v];
    endtask

    task automatic set_plan_const(input logic [2:0] r);
        for (int v = 0; v <= 24; v++) plan[v] = r;
    endtask

    int g_run;

    initial begin
        rst = 1'b1; start = 1'b0; resp = 3'b000;
        exp_we = 1'b0; exp_addr = 5'd0; exp_data = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst:A", A, 0);
        chk("rst:flags", {busy, done, mismatch, fail_seen}, 4'b0000);
        chk("rst:grade", grade, 0);
        chk("rst:err", err_count, 0);
        chk("rst:fail_addr", fail_addr, 0);
        rst = 1'b0;

        // Golden tables against a well-behaved chip
        for (int i = 0; i < 24; i++) tbl_m[i] = golden[i];
        load_table();
        set_plan_golden();
        run("golden", 1'b0, 1'b0, 1'b0, g_run);
        chk("golden:100", g_run, 100);
        repeat (4) @(negedge clk);
        chk("golden:hold_done", done, 1);
        chk("golden:hold_grade", grade, 100);

        // Stuck-at responses
        set_plan_const(3'b011);
        run("stuck011", 1'b0, 1'b0, 1'b0, g_run);
        chk("stuck011:78", g_run, 78);
        chk("stuck011:err9", err_count, 9);
        set_plan_const(3'b000);
        run("stuck000", 1'b0, 1'b0, 1'b0, g_run);
        chk("stuck000:34", g_run, 34);

        // Start pulses and table writes during a run are ignored
        set_plan_golden();
        run("guard", 1'b1, 1'b1, 1'b0, g_run);
        chk("guard:100", g_run, 100);
        run("after_guard", 1'b0, 1'b0, 1'b0, g_run);
        chk("after_guard:100", g_run, 100);

        // Reset partway through a run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; resp = 3'b011;
        repeat (19) begin
            @(negedge clk);
            resp = 3'($urandom);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("abort:A", A, 0);
        chk("abort:flags", {busy, done, mismatch, fail_seen}, 4'b0000);
        chk("abort:grade", grade, 0);
        chk("abort:err", err_count, 0);
        chk("abort:fail_addr", fail_addr, 0);
        rst = 1'b0;
        run("post_abort", 1'b0, 1'b0, 1'b0, g_run);
        chk("post_abort:100", g_run, 100);

        // Randomised tables and responses, first iteration also writes on the start edge
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < 24; i++) tbl_m[i] = 3'($urandom);
            if (it == 0) begin
                tbl_m[23] = ~tbl_m[23];
                load_table();
                tbl_m[23] = ~tbl_m[23];
            end else begin
                load_table();
            end
            plan[0] = 3'($urandom);
            for (int v = 0; v < 24; v++)
                plan[v+1] = ($urandom_range(0, 2) == 0) ? tbl_m[v] : 3'($urandom);
            run("random", 1'b0, 1'b0, (it == 0), g_run);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
